// File: rtl/mem_line_arbiter.sv
// Line-wide memory responder shared by the instruction and data caches.
// Serves one petition at a time after a fixed latency, round-robin on ties.
module mem_line_arbiter #(
  parameter int cache_line_width = 256,
  parameter int addr_width       = 16,
  parameter int mem_index_bits   = 6,
  parameter int mem_latency      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        iPetition,
  input  logic [addr_width-1:0]       iAddr,
  output logic                        iReady,
  input  logic                        dPetition,
  input  logic                        dWrite,
  input  logic [addr_width-1:0]       dAddr,
  input  logic [cache_line_width-1:0] dDataWrite,
  output logic                        dReady,
  output logic [cache_line_width-1:0] lineOut,
  output logic                        busy,
  output logic [1:0]                  fsmState
);

  localparam int CW = (mem_latency > 1) ? $clog2(mem_latency) : 1;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(mem_latency - 1);

  // Handshake: a petition is a level held by the cache; it is sampled only in
  // IDLE, and completion is a single-cycle iReady/dReady pulse from DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state, stateNext;
  logic [CW-1:0]               count;
  logic                        lastServed;   // 1 = data cache served last
  logic                        servingD;
  logic [mem_index_bits-1:0]   index;
  logic                        writeReg;
  logic [cache_line_width-1:0] dataReg;
  logic                        grant, grantD, access;

  logic [cache_line_width-1:0] mem [2**mem_index_bits];

  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
        if (iPetition && dPetition) begin
          grant  = 1'b1;
          grantD = ~lastServed;
        end else if (iPetition) begin
          grant = 1'b1;
        end else if (dPetition) begin
          grant  = 1'b1;
          grantD = 1'b1;
        end
        if (grant) stateNext = SERVE;
      end
      SERVE:   if (count == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign access = (state == SERVE) && (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      lastServed <= 1'b1;
      servingD   <= 1'b0;
      index      <= '0;
      writeReg   <= 1'b0;
      dataReg    <= '0;
      lineOut    <= '0;
    end else begin
      state <= stateNext;
      if (grant) begin
        servingD <= grantD;
        index    <= grantD ? dAddr[4 +: mem_index_bits] : iAddr[4 +: mem_index_bits];
        writeReg <= grantD & dWrite;
        dataReg  <= dDataWrite;
        count    <= COUNT_LOAD;
      end else if ((state == SERVE) && (count != '0)) begin
        count <= count - 1'b1;
      end
      if (access && !writeReg) lineOut <= mem[index];
      if (state == DONE) lastServed <= servingD;
    end
  end

  // Reset forces IDLE asynchronously, so an aborted write never reaches here.
  always_ff @(posedge clk) begin
    if (access && writeReg) mem[index] <= dataReg;
  end

  assign iReady   = (state == DONE) && !servingD;
  assign dReady   = (state == DONE) && servingD;
  assign busy     = (state != IDLE);
  assign fsmState = state;

  logic unusedAddrBits;
  assign unusedAddrBits = ^{iAddr[3:0], iAddr[addr_width-1:4+mem_index_bits],
                            dAddr[3:0], dAddr[addr_width-1:4+mem_index_bits]};

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
Memory-side responder for the fetch and data caches. It accepts line petitions from the instruction cache (read only) and the data cache (read or write-back), arbitrates between them, and services one petition at a time from a line-wide backing memory after a fixed latency. Completion is signalled with a one-cycle ready pulse to the served requester, and the read line is driven on the shared data bus.

Parameters:
cache_line_width, 256, bits per line (16 words of 16 bits)
addr_width, 16, word address width
mem_index_bits, 6, log2 of backing-memory lines (64 lines)
mem_latency, 4, cycles from grant to ready pulse (must be >=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears FSM/counter/outputs immediately
iPetition  in  1  instruction cache line read request (level, held until served)
iAddr  in  addr_width  instruction cache word address
iReady  out  1  one-cycle pulse: instruction line on lineOut
dPetition  in  1  data cache line request (level)
dWrite  in  1  1 = write-back of dDataWrite, 0 = line read
dAddr  in  addr_width  data cache word address
dDataWrite  in  cache_line_width  line to write back
dReady  out  1  one-cycle pulse: data request completed (line on lineOut for reads)
lineOut  out  cache_line_width  read line, valid only while iReady or dReady
busy  out  1  a petition is in service

Behaviour:
- Line index = addr[4 +: mem_index_bits]; addr[3:0] ignored; upper bits ignored (aliasing permitted).
- Backing memory: 2^mem_index_bits registers of cache_line_width; not cleared by reset; contents undefined until written.
- FSM states: IDLE, SERVE, DONE.
- IDLE: if no petition, stay. If one petition, grant it. If both, grant the requester not served last (lastServed flag, reset value = D, so I wins the first tie). On grant: latch requester id, index, dWrite, dDataWrite; load counter = mem_latency-1; go to SERVE; busy=1 from next cycle.
- SERVE: counter decrements each cycle; at counter==0 perform access: read captures line into lineOut register; write stores latched data into memory; go to DONE.
- DONE: assert iReady or dReady (per latched id) for exactly one cycle, lineOut valid same cycle; update lastServed; next state IDLE.
- Latency: petition sampled at edge T (in IDLE) -> ready high during cycle T+mem_latency+1; earliest next grant at edge after ready cycle (one IDLE cycle between services, allowing cache to drop petition after fill).
- Petitions are not re-sampled while busy; address/data changes after grant have no effect.
- Petition withdrawn during SERVE: service still completes; write still committed; ready pulse still issued.
- Write-back: dReady pulses; lineOut holds previous value (don't care).
- Read of a line being written in the same service cannot occur (one service at a time); read after completed write returns written data.
- Reset outputs: iReady=0, dReady=0, busy=0, lineOut=0, FSM=IDLE, counter=0, lastServed=D. Reset asserted mid-service aborts: no ready pulse, pending write not committed if access edge not yet reached.
- iReady and dReady never high together; never high for more than one cycle per grant.

Test Plan:
- dPetition=1,dWrite=1,dAddr=0x0010,dDataWrite=0xA5..A5 -> dReady pulse 5 cycles after grant edge; then iPetition, iAddr=0x0013 -> iReady pulse, lineOut=0xA5..A5.
- iPetition and dPetition(read) raised same cycle after reset -> I served first, then D; second grant one IDLE cycle after iReady; next tie grants I again (round-robin).
- Write line index 5 with pattern P, index 5+64 aliased address (0x0450) read -> returns P.
- iPetition dropped one cycle after grant -> iReady still pulses exactly once at T+5; FSM returns IDLE, busy=0.
- reset driven low two cycles into a write service -> outputs 0 immediately, no dReady; subsequent read of that line returns prior contents.
- Back-to-back continuous dPetition reads -> dReady pulses spaced mem_latency+2 cycles, never two consecutive high cycles, busy low only in IDLE cycles.
